bus_mem_resp: RTL and testbench

BUS_MEM_RESP -- requirements
Module: bus_mem_resp

---
 rtl/bus_mem_resp.sv | 242 ++++++++++++++++++++++++
 tb/tb_bus_mem_resp.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_resp.sv
// bus_mem_resp -- single-outstanding bus target in front of an inferred
// block RAM. A request is held in wait states, accepted with a one-cycle
// ready, and a read returns its word RD_LAT cycles after the handshake.
//
// Optional build macro: BUS_MEM_RESP_ADDR_CHECK_EN
//   defined   : addresses >= 2**MEM_AW are out of range. Writes to them are
//               dropped, reads return zero with normal timing, and err is
//               set and held until reset.
//   undefined : upper address bits are ignored (addresses alias) and err
//               is tied low.
module bus_mem_resp #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MEM_AW   = 10,
    parameter int WAIT_CYC = 2,
    parameter int RD_LAT   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] address,
    input  logic          wvalid,
    input  logic [DW-1:0] wdata,
    output logic          wready,
    input  logic          rvalid,
    output logic          rready,
    output logic          rrvalid,
    output logic [DW-1:0] rdata,
    output logic          err
);

    // One counter serves both the wait-state countdown and the read
    // latency countdown; the two phases never overlap.
    localparam int CW    = 4;
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;

    // Latched operation type: 1 = write, 0 = read.
    logic              r_op_write;

    // Valid of the latched operation; low means the request was withdrawn.
    logic              w_op_valid;

    logic              w_wr_hs;
    logic              w_rd_hs;
    logic              w_oor;
    logic [MEM_AW-1:0] w_idx;

    logic [DW-1:0]     r_mem [0:DEPTH-1];
    logic [DW-1:0]     r_rd_word;
    logic              r_rd_oor;
    logic [DW-1:0]     r_rdata_hold;
    logic [DW-1:0]     w_resp_data;

    assign w_idx      = address[MEM_AW-1:0];
    assign w_op_valid = r_op_write ? wvalid : rvalid;

    // Handshakes are gated by reset so a reset landing on an ACK cycle
    // cannot leak a memory write or launch a read response.
    assign w_wr_hs = wvalid & wready & rst_n;
    assign w_rd_hs = rvalid & rready & rst_n;

    // ------------------------------------------------------------------
    // Address range check (optional)
    // ------------------------------------------------------------------
`ifdef BUS_MEM_RESP_ADDR_CHECK_EN
    generate
        if (MEM_AW < AW) begin : g_oor
            assign w_oor = |address[AW-1:MEM_AW];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    logic r_err;

    // Sticky error: any handshake to an out-of-range address sets it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((w_wr_hs | w_rd_hs) & w_oor) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    // Upper address bits alias onto the memory; they are deliberately unused.
    logic w_unused_addr;
    assign w_unused_addr = ^address;
    assign w_oor         = 1'b0;
    assign err           = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State and shared counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state and counter: wait states, withdrawal, handshake, latency.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (wvalid | rvalid) begin
                    if (WAIT_CYC == 0) begin
                        w_state_next = S_ACK;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = CW'(WAIT_CYC);
                    end
                end
            end
            S_WAIT: begin
                if (!w_op_valid) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt <= CW'(1)) begin
                    w_state_next = S_ACK;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            S_ACK: begin
                // Ready follows valid here, so a still-valid request always
                // completes its handshake in this cycle.
                if (!w_op_valid || r_op_write) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = S_RESP;
                    w_cnt_next   = CW'(RD_LAT);
                end
            end
            S_RESP: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs: ready only in ACK for the latched op, response pulse at count 1.
    always_comb begin
        wready  = 1'b0;
        rready  = 1'b0;
        rrvalid = 1'b0;
        case (r_state)
            S_ACK: begin
                wready = wvalid & r_op_write;
                rready = rvalid & ~r_op_write;
            end
            S_RESP: begin
                rrvalid = (r_cnt == CW'(1));
            end
            default: begin
                wready  = 1'b0;
                rready  = 1'b0;
                rrvalid = 1'b0;
            end
        endcase
    end

    // Latch the operation type when a request is first seen; write wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_write <= 1'b0;
        end else if ((r_state == S_IDLE) && (wvalid | rvalid)) begin
            r_op_write <= wvalid;
        end
    end

    // ------------------------------------------------------------------
    // Memory and read datapath
    // ------------------------------------------------------------------

    // Block RAM: write on write handshake, registered read on read handshake.
    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_hs && !w_oor) begin
            r_mem[w_idx] <= wdata;
        end
        if (w_rd_hs) begin
            r_rd_word <= r_mem[w_idx];
        end
    end

    // Remember whether the in-flight read was out of range (forces zero data).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_oor <= 1'b0;
        end else if (w_rd_hs) begin
            r_rd_oor <= w_oor;
        end
    end

    assign w_resp_data = r_rd_oor ? '0 : r_rd_word;

    // Capture each delivered response so rdata holds it until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata_hold <= '0;
        end else if (rrvalid) begin
            r_rdata_hold <= w_resp_data;
        end
    end

    // The response word is presented during the rrvalid cycle itself, which
    // keeps RD_LAT=1 possible without a second pipeline register.
    assign rdata = rrvalid ? w_resp_data : r_rdata_hold;

endmodule

// File: tb/tb_bus_mem_resp.sv
// Testbench for bus_mem_resp: directed bus transactions; expected read
// responses go into a scoreboard queue and a negedge monitor checks them.
module tb_bus_mem_resp;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int MEM_AW   = 10;
    localparam int WAIT_CYC = 2;
    localparam int RD_LAT   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] address = '0;
    logic          wvalid = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wready;
    logic          rvalid = 1'b0;
    logic          rready;
    logic          rrvalid;
    logic [DW-1:0] rdata;
    logic          err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        string         name;
    } resp_t;

    resp_t         exp_q[$];
    logic [DW-1:0] hold_val = '0;

    bus_mem_resp #(
        .AW      (AW),
        .DW      (DW),
        .MEM_AW  (MEM_AW),
        .WAIT_CYC(WAIT_CYC),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .address(address),
        .wvalid (wvalid),
        .wdata  (wdata),
        .wready (wready),
        .rvalid (rvalid),
        .rready (rready),
        .rrvalid(rrvalid),
        .rdata  (rdata),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every rrvalid; otherwise rdata must hold.
    always @(negedge clk) begin
        if (rrvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rrvalid", {31'd0, rrvalid}, 32'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check({e.name, "_rdata"}, {16'd0, rdata}, {16'd0, e.data});
                check({e.name, "_rrvalid_cycle"}, cyc, e.cyc);
                $display("[TB] read %s resp data=0x%04h at cycle %0d", e.name, rdata, cyc);
                hold_val = e.data;
            end
        end else if (rst_n) begin
            check("rdata_hold", {16'd0, rdata}, {16'd0, hold_val});
        end
        if (!rst_n) hold_val = '0;
    end

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input string nm, input bit sync);
        int t0;
        bit seen;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        address = a;
        wdata   = d;
        wvalid  = 1'b1;
        t0      = cyc;
        seen    = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (wready) begin
                seen = 1'b1;
                check({nm, "_wready_lat"}, cyc - t0, WAIT_CYC + 1);
                $display("[TB] write %s addr=0x%04h data=0x%04h ready at cycle %0d",
                         nm, a, d, cyc - t0);
            end
        end
        check({nm, "_wready_seen"}, {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        @(negedge clk);
        check({nm, "_wready_low_after"}, {31'd0, wready}, 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                           input string nm);
        int t0;
        bit seen;
        @(posedge clk);
        #1;
        address = a;
        rvalid  = 1'b1;
        t0      = cyc;
        seen    = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rready) begin
                seen = 1'b1;
                check({nm, "_rready_lat"}, cyc - t0, WAIT_CYC + 1);
                exp_q.push_back('{data: exp, cyc: cyc + RD_LAT, name: nm});
            end
        end
        check({nm, "_rready_seen"}, {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        wait_drain(nm);
    endtask

    initial begin
        int  t0;
        bit  seen;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_rrvalid", {31'd0, rrvalid}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic write then read back
        do_write(16'h0010, 16'hBEEF, "wr10", 1'b1);
        do_read(16'h0010, 16'hBEEF, "rd10");
        repeat (3) @(negedge clk);
        check("rd10_held", {16'd0, rdata}, 32'h0000BEEF);

        // Write and read raised together: write first, read re-seen at cycle 4
        @(posedge clk);
        #1;
        address = 16'h0020;
        wdata   = 16'h5A5A;
        wvalid  = 1'b1;
        rvalid  = 1'b1;
        t0      = cyc;
        seen    = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (wready || rready) begin
                seen = 1'b1;
                check("both_first_is_write", {30'd0, wready, rready}, 32'd2);
                check("both_wready_lat", cyc - t0, 3);
            end
        end
        check("both_wready_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        seen   = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rready) begin
                seen = 1'b1;
                check("both_rready_cycle", cyc - t0, 7);
                exp_q.push_back('{data: 16'h5A5A, cyc: cyc + RD_LAT, name: "both_rd"});
            end
        end
        check("both_rready_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        wait_drain("both");

        // Read withdrawn at cycle 2: no ready, no response, IDLE by cycle 3
        @(posedge clk);
        #1;
        address = 16'h0030;
        rvalid  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("wd_rready_low", {31'd0, rready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rvalid = 1'b0;
        @(negedge clk);
        check("wd_rready_low_c2", {31'd0, rready}, 32'd0);
        @(posedge clk);
        #1;
        // Cycle 3: a fresh write must see ready three cycles later
        do_write(16'h0030, 16'h1111, "wd_wr30", 1'b0);
        do_read(16'h0030, 16'h1111, "rd30");

        // Reset during RESP: no response, rdata cleared, memory kept
        @(posedge clk);
        #1;
        address = 16'h0010;
        rvalid  = 1'b1;
        seen    = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rready) seen = 1'b1;
        end
        check("rstresp_rready_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rstresp_rrvalid", {31'd0, rrvalid}, 32'd0);
        end
        check("rstresp_rdata", {16'd0, rdata}, 32'd0);
        check("rstresp_err", {31'd0, err}, 32'd0);
        do_read(16'h0010, 16'hBEEF, "rd10_after_rst");

        // Out-of-range / aliasing
        do_write(16'h0000, 16'hAAAA, "wr00", 1'b1);
        do_write(16'h0400, 16'h1234, "wr400", 1'b1);
`ifdef BUS_MEM_RESP_ADDR_CHECK_EN
        check("oor_err", {31'd0, err}, 32'd1);
        do_read(16'h0000, 16'hAAAA, "rd00_kept");
        do_read(16'h0400, 16'h0000, "rd400_zero");
        check("oor_err_sticky", {31'd0, err}, 32'd1);
`else
        check("alias_err", {31'd0, err}, 32'd0);
        do_read(16'h0000, 16'h1234, "rd00_alias");
        do_read(16'h0400, 16'h1234, "rd400_alias");
        check("alias_err_after", {31'd0, err}, 32'd0);
`endif

        // Address boundaries inside the memory
        do_write(16'h03FF, 16'hFFFF, "wr3ff", 1'b1);
        do_write(16'h0001, 16'h0001, "wr001", 1'b1);
        do_read(16'h03FF, 16'hFFFF, "rd3ff");
        do_read(16'h0001, 16'h0001, "rd001");
        do_read(16'h0020, 16'h5A5A, "rd20");

        repeat (3) @(negedge clk);
        check("final_rdata_held", {16'd0, rdata}, 32'h00005A5A);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
